// File: rtl/pulse_emitter.sv
// pulse_emitter: turns single-cycle pulse events from a delay buffer into
// fixed-width TTL output pulses, each followed by an enforced dead time.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   en            emitter enable; when low, new events are ignored
//   pulse_valid   pulse_in carries valid buffer data this cycle
//   pulse_in      delayed pulse sample from the buffer
//   ttl_out       registered TTL output, high exactly while in HIGH
//   busy          registered, high while in HIGH or DEAD
//   emitted_count saturating count of accepted pulses
//   dropped_count saturating count of pulses rejected while busy
module pulse_emitter #(
   parameter int PULSE_WIDTH = 10,
   parameter int DEAD_TIME   = 5,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 pulse_valid,
   input  logic                 pulse_in,
   output logic                 ttl_out,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] emitted_count,
   output logic [CNT_WIDTH-1:0] dropped_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      DEAD = 2'd2
   } state_t;

   // Timer reload values; the timer counts down to zero inclusive,
   // so a phase of N cycles loads N-1.
   localparam logic [7:0] PW_LOAD = 8'(PULSE_WIDTH - 1);
   localparam logic [7:0] DT_LOAD =
      (DEAD_TIME > 0) ? 8'(DEAD_TIME - 1) : 8'd0;
   localparam bit NO_DEAD = (DEAD_TIME == 0);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE =
      {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     state_nx;
   logic [7:0] timer;
   logic [7:0] timer_nx;
   logic       ttl_nx;
   logic       busy_nx;
   logic       ev;
   logic       accept;
   logic       drop;

   // Acceptance looks only at the registered state, so an event on the
   // last DEAD cycle is still seen as busy and dropped.
   assign ev     = pulse_in & pulse_valid & en;
   assign accept = ev & (state == IDLE);
   assign drop   = ev & (state != IDLE);

   // State register; outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= 8'd0;
         ttl_out <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         ttl_out <= ttl_nx;
         busy    <= busy_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      timer_nx = timer;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = HIGH;
               timer_nx = PW_LOAD;
            end
         end
         HIGH: begin
            if (timer == 8'd0) begin
               if (NO_DEAD) begin
                  state_nx = IDLE;
                  timer_nx = 8'd0;
               end else begin
                  state_nx = DEAD;
                  timer_nx = DT_LOAD;
               end
            end else begin
               timer_nx = timer - 8'd1;
            end
         end
         DEAD: begin
            if (timer == 8'd0) begin
               state_nx = IDLE;
            end else begin
               timer_nx = timer - 8'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            timer_nx = 8'd0;
         end
      endcase
   end

   // Output logic: decoded from the next state so the registered
   // outputs match the state register cycle for cycle.
   always_comb begin
      ttl_nx  = (state_nx == HIGH);
      busy_nx = (state_nx != IDLE);
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         emitted_count <= '0;
         dropped_count <= '0;
      end else begin
         if (accept && (emitted_count != CNT_MAX)) begin
            emitted_count <= emitted_count + CNT_ONE;
         end
         if (drop && (dropped_count != CNT_MAX)) begin
            dropped_count <= dropped_count + CNT_ONE;
         end
      end
   end

endmodule
